// File: rtl/nios_sw_poller.sv
// nios_sw_poller: Avalon-MM read master that polls a switch PIO at a fixed
// interval, debounces the returned value and presents it to fabric logic
// with a one-cycle change strobe.
module nios_sw_poller #(
    parameter int POLL_DIV     = 50000,
    parameter int READ_LATENCY = 1,
    parameter int STABLE_COUNT = 4,
    parameter int DATA_W       = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] sw_value,
    output logic              sw_valid,
    output logic              sw_changed
);

    localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam int STB_W = $clog2(STABLE_COUNT + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_COUNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EVAL
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_poll_cnt;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [STB_W-1:0]   r_stable_cnt;
    logic [DATA_W-1:0]  r_last_sample;
    logic [DATA_W-1:0]  r_sw_value;
    logic               r_sw_valid;
    logic               r_sw_changed;
    logic               r_read;

    logic               w_tick;
    logic               w_accept;
    logic               w_capture;
    logic               w_same;
    logic [DATA_W-1:0]  w_sample;
    logic [DATA_W-1:0]  w_diff;

    // Only the low DATA_W bits of the PIO data carry switch state.
    assign w_sample = avm_readdata[DATA_W-1:0];

    generate
        if (DATA_W < 32) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^avm_readdata[31:DATA_W];
        end
    endgenerate

    // Bitwise comparison of the new sample against the last one seen.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_diff
            assign w_diff[gi] = w_sample[gi] ^ r_last_sample[gi];
        end
    endgenerate

    assign w_same    = ~|w_diff;
    assign w_tick    = enable && (r_poll_cnt == CNT_LAST);
    assign w_accept  = (r_state == S_REQ) && !avm_waitrequest;
    assign w_capture = (r_state == S_WAIT) && (r_lat_cnt == LAT_W'(1));

    assign avm_address = 2'b00;
    assign avm_read    = r_read;
    assign sw_value    = r_sw_value;
    assign sw_valid    = r_sw_valid;
    assign sw_changed  = r_sw_changed;

    // Free-running poll interval counter; parked at zero while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_poll_cnt <= '0;
        end else if (!enable || (r_poll_cnt == CNT_LAST)) begin
            r_poll_cnt <= '0;
        end else begin
            r_poll_cnt <= r_poll_cnt + CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state; ticks outside IDLE are simply not looked at, so they drop.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_tick) w_state_next = S_REQ;
            S_REQ:  if (!avm_waitrequest) w_state_next = S_WAIT;
            S_WAIT: if (r_lat_cnt == LAT_W'(1)) w_state_next = S_EVAL;
            S_EVAL: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Registered read strobe: high exactly for the cycles spent in REQ.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_read <= 1'b0;
        end else begin
            r_read <= (w_state_next == S_REQ);
        end
    end

    // Read latency countdown, loaded on accept and decremented while waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lat_cnt <= '0;
        end else if (w_accept) begin
            r_lat_cnt <= LAT_LOAD;
        end else if ((r_state == S_WAIT) && (r_lat_cnt != LAT_W'(1))) begin
            r_lat_cnt <= r_lat_cnt - LAT_W'(1);
        end
    end

    // Debounce tracking: count identical consecutive samples, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_sample <= '0;
            r_stable_cnt  <= '0;
        end else if (w_capture) begin
            if (w_same && (r_stable_cnt != '0)) begin
                if (r_stable_cnt != STB_MAX) begin
                    r_stable_cnt <= r_stable_cnt + STB_W'(1);
                end
            end else begin
                r_last_sample <= w_sample;
                r_stable_cnt  <= STB_W'(1);
            end
        end
    end

    // Publish a qualified value in EVAL and strobe only when it differs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sw_value   <= '0;
            r_sw_valid   <= 1'b0;
            r_sw_changed <= 1'b0;
        end else begin
            r_sw_changed <= 1'b0;
            if ((r_state == S_EVAL) && (r_stable_cnt == STB_MAX) &&
                (!r_sw_valid || (r_last_sample != r_sw_value))) begin
                r_sw_value   <= r_last_sample;
                r_sw_valid   <= 1'b1;
                r_sw_changed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nios_sw_poller.sv
// tb_nios_sw_poller: directed bench for nios_sw_poller with a registered-data
// PIO slave model; expected values are hand-derived per absolute cycle.
module tb_nios_sw_poller;

    localparam int POLL_DIV     = 8;
    localparam int READ_LATENCY = 1;
    localparam int STABLE_COUNT = 3;
    localparam int DATA_W       = 4;

    logic              clk;
    logic              reset_n;
    logic              enable;
    logic [1:0]        avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata = 32'h0;
    logic [DATA_W-1:0] sw_value;
    logic              sw_valid;
    logic              sw_changed;

    logic [DATA_W-1:0] sw;
    int                cyc;
    int                n_checks;
    int                n_pass;

    nios_sw_poller #(
        .POLL_DIV     (POLL_DIV),
        .READ_LATENCY (READ_LATENCY),
        .STABLE_COUNT (STABLE_COUNT),
        .DATA_W       (DATA_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .sw_value        (sw_value),
        .sw_valid        (sw_valid),
        .sw_changed      (sw_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO slave: registered readdata, junk in the unused upper bits.
    always @(posedge clk) begin
        if (avm_read && !avm_waitrequest) begin
            avm_readdata <= {28'hA5A5A5A, sw};
            $display("poll accepted in cycle %0d, switches=%b", cyc, sw);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic exp_read(input int c);
        if (c > 0 && c <= 104 && (c % 8) == 0) return 1'b1;
        if (c >= 112 && c <= 122) return 1'b1;
        if (c == 128 || c == 136 || c == 144 || c == 179) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [DATA_W-1:0] exp_value(input int c);
        if (c < 27) return 4'b0000;
        if (c < 99) return 4'b1010;
        if (c < 139) return 4'b0011;
        return 4'b0110;
    endfunction

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        cyc             = 0;
        reset_n         = 1'b0;
        enable          = 1'b1;
        avm_waitrequest = 1'b0;
        sw              = 4'b1010;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Main run: cycle 0 is the cycle in which reset is released.
        for (int c = 0; c <= 180; c++) begin
            cyc = c;
            case (c)
                31:  sw = 4'b0101;
                36:  sw = 4'b1010;
                44:  sw = 4'b0101;
                52:  sw = 4'b1010;
                60:  sw = 4'b0101;
                68:  sw = 4'b1010;
                76:  sw = 4'b0011;
                111: begin sw = 4'b0110; avm_waitrequest = 1'b1; end
                122: avm_waitrequest = 1'b0;
                141: sw = 4'b1001;
                144: enable = 1'b0;
                171: enable = 1'b1;
                default: ;
            endcase
            #1;
            check("avm_read", 32'(avm_read), 32'(exp_read(c)));
            check("sw_changed", 32'(sw_changed), 32'((c == 27) || (c == 99) || (c == 139)));
            check("sw_value", 32'(sw_value), 32'(exp_value(c)));
            check("sw_valid", 32'(sw_valid), 32'(c >= 27));
            if (c == 8) check("avm_address", 32'(avm_address), 32'h0);
            if (c >= 34 && c <= 74 && (c % 8) == 2) check("stable_cnt_toggle", 32'(dut.r_stable_cnt), 32'd1);
            if (c == 146) begin
                check("stable_cnt_en_drop", 32'(dut.r_stable_cnt), 32'd1);
                check("last_sample_en_drop", 32'(dut.r_last_sample), 32'b1001);
            end
            if (c < 180) @(negedge clk);
        end

        // Reset asserted while the poll issued in cycle 179 is in WAIT.
        reset_n = 1'b0;
        #1;
        check("rst_avm_read", 32'(avm_read), 32'h0);
        check("rst_sw_value", 32'(sw_value), 32'h0);
        check("rst_sw_valid", 32'(sw_valid), 32'h0);
        check("rst_sw_changed", 32'(sw_changed), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int c = 0; c <= 12; c++) begin
            cyc = 1000 + c;
            #1;
            check("post_rst_avm_read", 32'(avm_read), 32'(c == 8));
            check("post_rst_sw_valid", 32'(sw_valid), 32'h0);
            check("post_rst_sw_value", 32'(sw_value), 32'h0);
            if (c < 12) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
